// File: rtl/ld_pkg.sv
// Shared definitions for the laser-diode sequencer: state codes and current thresholds.
package ld_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StRamp   = 3'd2,
    StHold   = 3'd3,
    StRampDn = 3'd4,
    StFlt    = 3'd5
  } ld_state_e;

  localparam int unsigned IMonW = 12;

  localparam logic [IMonW-1:0] ITargetDflt = 12'd2000;
  localparam logic [IMonW-1:0] IZeroDflt   = 12'd1;

  // States in which the driver switch is closed.
  function automatic logic st_active(ld_state_e st);
    return (st == StArm) || (st == StRamp) || (st == StHold) || (st == StRampDn);
  endfunction

  // States in which the diode is commanded to emit.
  function automatic logic st_emitting(ld_state_e st);
    return (st == StRamp) || (st == StHold);
  endfunction

endpackage

// File: rtl/ld_seq_timer.sv
// State-dwell counter: cleared synchronously on every state change, counts up otherwise.
module ld_seq_timer #(
  parameter int unsigned CW = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ld_sequencer.sv
// Supervisory FSM for the laser-diode driver: arm, ramp-up, hold, ramp-down, with
// interlock and ramp-timeout faults latched until acknowledged.
module ld_sequencer
  import ld_pkg::*;
#(
  parameter int unsigned      T_ARM     = 100,
  parameter int unsigned      T_EMIT    = 1000000,
  parameter int unsigned      T_TIMEOUT = 4000000,
  parameter logic [IMonW-1:0] I_TARGET  = ITargetDflt,
  parameter logic [IMonW-1:0] I_ZERO    = IZeroDflt,
  parameter int unsigned      CW        = 24
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             START,
  input  logic             STOP,
  input  logic             INTLK_OK,
  input  logic             CLR_FAULT,
  input  logic [IMonW-1:0] I_MON,
  output logic             SW_ON,
  output logic             LD_ON,
  output logic             READY,
  output logic             BUSY,
  output logic             FAULT,
  output logic             DONE,
  output logic [2:0]       STATE
);

  localparam logic [CW-1:0] ArmLast     = CW'(T_ARM - 1);
  localparam logic [CW-1:0] EmitLast    = CW'(T_EMIT - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(T_TIMEOUT - 1);

  ld_state_e     state_q, state_d;
  logic          done_q, done_d;
  logic [CW-1:0] timer_q;
  logic          timer_clr;
  logic          at_target, at_zero;

  assign at_target = (I_MON >= I_TARGET);
  assign at_zero   = (I_MON <= I_ZERO);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (START && INTLK_OK && !STOP) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (!INTLK_OK) begin
          state_d = StFlt;
        end else if (STOP) begin
          state_d = StIdle;
        end else if (timer_q == ArmLast) begin
          state_d = StRamp;
        end
      end
      StRamp: begin
        // Reaching target outranks STOP so an on-target stop still passes through HOLD.
        if (!INTLK_OK) begin
          state_d = StFlt;
        end else if (at_target) begin
          state_d = StHold;
        end else if (STOP) begin
          state_d = StRampDn;
        end else if (timer_q == TimeoutLast) begin
          state_d = StFlt;
        end
      end
      StHold: begin
        if (!INTLK_OK) begin
          state_d = StFlt;
        end else if (STOP || (timer_q == EmitLast)) begin
          state_d = StRampDn;
        end
      end
      StRampDn: begin
        if (!INTLK_OK) begin
          state_d = StFlt;
        end else if (at_zero) begin
          state_d = StIdle;
        end else if (timer_q == TimeoutLast) begin
          state_d = StFlt;
        end
      end
      StFlt: begin
        if (CLR_FAULT && INTLK_OK && at_zero) begin
          state_d = StIdle;
        end
      end
      default: state_d = StFlt;
    endcase
  end

  always_comb begin
    done_d    = (state_q == StRampDn) && (state_d == StIdle);
    timer_clr = (state_d != state_q);
  end

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  ld_seq_timer #(
    .CW(CW)
  ) u_timer (
    .clk_i(CLK),
    .rst_i(Clr),
    .clr_i(timer_clr),
    .cnt_o(timer_q)
  );

  // Outputs depend only on flopped state so reset drops the driver enables at once.
  always_comb begin
    SW_ON = st_active(state_q);
    LD_ON = st_emitting(state_q);
    READY = (state_q == StIdle);
    BUSY  = st_active(state_q);
    FAULT = (state_q == StFlt);
    DONE  = done_q;
    STATE = state_q;
  end

endmodule

// File: tb/tb_ld_sequencer.sv
// Bench for ld_sequencer: scenario tasks plus random stimulus against a cycle-level spec model.
module tb_ld_sequencer;

  localparam int TArm = 4;
  localparam int TEmit = 20;
  localparam int TTimeout = 50;
  localparam int ITarget = 2000;
  localparam int IZero = 1;
  localparam int Step = 100;

  localparam int S_IDLE = 0;
  localparam int S_ARM = 1;
  localparam int S_RAMP = 2;
  localparam int S_HOLD = 3;
  localparam int S_RAMPDN = 4;
  localparam int S_FLT = 5;

  // {STATE, SW_ON, LD_ON, READY, BUSY, FAULT, DONE}
  localparam logic [8:0] VIdle   = 9'b000_0_0_1_0_0_0;
  localparam logic [8:0] VArm    = 9'b001_1_0_0_1_0_0;
  localparam logic [8:0] VRampDn = 9'b100_1_0_0_1_0_0;
  localparam logic [8:0] VFlt    = 9'b101_0_0_0_0_1_0;

  logic        CLK = 1'b0;
  logic        Clr, START, STOP, INTLK_OK, CLR_FAULT;
  logic [11:0] I_MON;
  logic        SW_ON, LD_ON, READY, BUSY, FAULT, DONE;
  logic [2:0]  STATE;
  logic [8:0]  obs;

  int n_cmp = 0;
  int n_fail = 0;
  int m_state, m_t, m_imon;
  bit m_done;
  bit freeze;
  int freeze_val;

  ld_sequencer #(
    .T_ARM(TArm),
    .T_EMIT(TEmit),
    .T_TIMEOUT(TTimeout),
    .I_TARGET(12'd2000),
    .I_ZERO(12'd1),
    .CW(24)
  ) dut (
    .CLK(CLK),
    .Clr(Clr),
    .START(START),
    .STOP(STOP),
    .INTLK_OK(INTLK_OK),
    .CLR_FAULT(CLR_FAULT),
    .I_MON(I_MON),
    .SW_ON(SW_ON),
    .LD_ON(LD_ON),
    .READY(READY),
    .BUSY(BUSY),
    .FAULT(FAULT),
    .DONE(DONE),
    .STATE(STATE)
  );

  assign obs = {STATE, SW_ON, LD_ON, READY, BUSY, FAULT, DONE};

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_ld(int s);
    return (s == S_RAMP) || (s == S_HOLD);
  endfunction

  // Next state straight from the behaviour rules; t is cycles already spent in s.
  function automatic int ref_next(int s, int t, bit start, bit stop, bit intlk, bit clr, int imon);
    if (s == S_IDLE) return (start && intlk && !stop) ? S_ARM : S_IDLE;
    if (s == S_FLT) return (clr && intlk && imon <= IZero) ? S_IDLE : S_FLT;
    if (!intlk) return S_FLT;
    if (s == S_ARM) begin
      if (stop) return S_IDLE;
      return (t == TArm - 1) ? S_RAMP : S_ARM;
    end
    if (s == S_RAMP) begin
      if (imon >= ITarget) return S_HOLD;
      if (stop) return S_RAMPDN;
      return (t == TTimeout - 1) ? S_FLT : S_RAMP;
    end
    if (s == S_HOLD) return (stop || t == TEmit - 1) ? S_RAMPDN : S_HOLD;
    if (s == S_RAMPDN) begin
      if (imon <= IZero) return S_IDLE;
      return (t == TTimeout - 1) ? S_FLT : S_RAMPDN;
    end
    return S_FLT;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic act, ld;
    act = (m_state >= S_ARM) && (m_state <= S_RAMPDN);
    ld = ref_ld(m_state);
    return {3'(m_state), act, ld, m_state == S_IDLE, act, m_state == S_FLT, m_done};
  endfunction

  // One clock: advance the model and the driver current model, return at the negedge.
  task automatic step();
    int ns;
    @(posedge CLK);
    if (Clr) begin
      ns = S_IDLE;
      m_done = 1'b0;
      m_t = 0;
    end else begin
      ns = ref_next(m_state, m_t, START, STOP, INTLK_OK, CLR_FAULT, m_imon);
      m_done = (m_state == S_RAMPDN) && (ns == S_IDLE);
      m_t = (ns == m_state) ? m_t + 1 : 0;
    end
    if (freeze) m_imon = freeze_val;
    else if (ref_ld(m_state)) m_imon = (m_imon + Step > 4095) ? 4095 : m_imon + Step;
    else m_imon = (m_imon < Step) ? 0 : m_imon - Step;
    m_state = ns;
    @(negedge CLK);
    I_MON = 12'(m_imon);
  endtask

  task automatic run_to(input int st, input int budget);
    for (int i = 0; i < budget && m_state != st; i++) step();
    if (m_state != st) begin
      n_fail++;
      $display("FAIL run_to: model never reached state %0d", st);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 100 && m_imon != 0; i++) step();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    #1;
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, VIdle);
    end
    START = 1'b1;
    step();
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL reset_held_start: got %b expected %b", obs, VIdle);
    end
    START = 1'b0;
    Clr = 1'b0;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 8; i++) begin
      START = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        INTLK_OK = 1'b0;
        STOP = 1'b0;
      end else begin
        INTLK_OK = 1'b1;
        STOP = 1'b1;
      end
      CLR_FAULT = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if (obs !== VIdle) begin
        n_fail++;
        $display("FAIL idle_hold[%0d] intlk=%0b stop=%0b: got %b expected %b",
                 i, INTLK_OK, STOP, obs, VIdle);
      end
    end
    START = 1'b0;
    STOP = 1'b0;
    INTLK_OK = 1'b1;
    CLR_FAULT = 1'b0;
  endtask

  task automatic test_nominal();
    int arm_n = 0;
    int hold_n = 0;
    int done_n = 0;
    bit seen = 0;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL nominal cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (STATE == 3'd1) arm_n++;
      if (STATE == 3'd3) hold_n++;
      if (DONE === 1'b1) done_n++;
      if (m_done) begin
        seen = 1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!seen || READY !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_ready: got %b expected 1 (done reached=%0b)", READY, seen);
    end
    n_cmp++;
    if (arm_n != TArm) begin
      n_fail++;
      $display("FAIL nominal_arm_len: got %0d expected %0d", arm_n, TArm);
    end
    n_cmp++;
    if (hold_n != TEmit) begin
      n_fail++;
      $display("FAIL nominal_hold_len: got %0d expected %0d", hold_n, TEmit);
    end
    n_cmp++;
    if (done_n != 1) begin
      n_fail++;
      $display("FAIL nominal_done_count: got %0d expected 1", done_n);
    end
    step();
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL nominal_done_one_cycle: got %b expected %b", obs, VIdle);
    end
  endtask

  task automatic test_early_stop();
    settle();
    pulse_start();
    run_to(S_HOLD, 100);
    step();
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    n_cmp++;
    if (obs !== VRampDn) begin
      n_fail++;
      $display("FAIL early_stop_rampdn: got %b expected %b", obs, VRampDn);
    end
    for (int i = 0; i < 100 && m_state != S_IDLE; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL early_stop cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_intlk_drop();
    int k;
    settle();
    pulse_start();
    run_to(S_RAMP, 50);
    k = $urandom_range(8, 15);
    for (int i = 0; i < k; i++) step();
    INTLK_OK = 1'b0;
    step();
    INTLK_OK = 1'b1;
    n_cmp++;
    if (obs !== VFlt) begin
      n_fail++;
      $display("FAIL intlk_drop_flt: got %b expected %b", obs, VFlt);
    end
    for (int i = 0; i < 100 && m_imon != 500; i++) step();
    CLR_FAULT = 1'b1;
    step();
    CLR_FAULT = 1'b0;
    n_cmp++;
    if (obs !== VFlt) begin
      n_fail++;
      $display("FAIL intlk_clr_at_500: got %b expected %b", obs, VFlt);
    end
    settle();
    CLR_FAULT = 1'b1;
    step();
    CLR_FAULT = 1'b0;
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL intlk_clr_at_0: got %b expected %b", obs, VIdle);
    end
  endtask

  task automatic test_timeout();
    int ramp_n = 0;
    settle();
    freeze = 1'b1;
    freeze_val = 1500;
    m_imon = 1500;
    I_MON = 12'd1500;
    pulse_start();
    for (int i = 0; i < 120 && m_state != S_FLT; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
      if (STATE == 3'd2) ramp_n++;
      step();
    end
    n_cmp++;
    if (ramp_n != TTimeout) begin
      n_fail++;
      $display("FAIL timeout_ramp_len: got %0d expected %0d", ramp_n, TTimeout);
    end
    n_cmp++;
    if (obs !== VFlt) begin
      n_fail++;
      $display("FAIL timeout_flt: got %b expected %b", obs, VFlt);
    end
    freeze = 1'b0;
    settle();
    CLR_FAULT = 1'b1;
    step();
    CLR_FAULT = 1'b0;
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected %b", obs, VIdle);
    end
  endtask

  task automatic test_async_reset();
    settle();
    pulse_start();
    run_to(S_HOLD, 100);
    step();
    step();
    #2 Clr = 1'b1;
    #1;
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs, VIdle);
    end
    step();
    Clr = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    n_cmp++;
    if (obs !== VArm) begin
      n_fail++;
      $display("FAIL async_reset_restart: got %b expected %b", obs, VArm);
    end
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    n_cmp++;
    if (obs !== VIdle) begin
      n_fail++;
      $display("FAIL arm_stop_idle: got %b expected %b", obs, VIdle);
    end
  endtask

  task automatic test_back_to_back();
    settle();
    START = 1'b1;
    for (int i = 0; i < 200 && !m_done; i++) step();
    step();
    n_cmp++;
    if (obs !== VArm) begin
      n_fail++;
      $display("FAIL back_to_back_rearm: got %b expected %b", obs, VArm);
    end
    START = 1'b0;
    STOP = 1'b1;
    step();
    STOP = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      START = ($urandom_range(0, 2) == 0);
      STOP = ($urandom_range(0, 15) == 0);
      INTLK_OK = ($urandom_range(0, 39) != 0);
      CLR_FAULT = ($urandom_range(0, 3) == 0);
      Clr = ($urandom_range(0, 63) == 0);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", i, obs, exp_vec());
      end
    end
    Clr = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    INTLK_OK = 1'b1;
    CLR_FAULT = 1'b0;
  endtask

  initial begin
    Clr = 1'b1;
    START = 1'b0;
    STOP = 1'b0;
    INTLK_OK = 1'b1;
    CLR_FAULT = 1'b0;
    I_MON = 12'd0;
    m_state = S_IDLE;
    m_t = 0;
    m_imon = 0;
    m_done = 1'b0;
    freeze = 1'b0;
    freeze_val = 0;
    test_reset();
    test_idle_hold();
    test_nominal();
    test_early_stop();
    test_intlk_drop();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ld_sequencer.md
Name: ld_sequencer

Overview:
- Supervisory controller for the laser-diode current driver.
- Generates the driver's SW_ON and LD_ON inputs from operator START/STOP commands and a safety interlock.
- Runs a timed emission cycle (arm, ramp-up, hold, ramp-down) and enforces ramp timeouts, latching a fault on any violation.
- Sits between the front-panel/command logic and the driver; reads the driver's 12-bit current output back as I_MON.

Parameters:
- T_ARM, 100, cycles SW_ON is held before LD_ON asserts (driver settle).
- T_EMIT, 1000000, cycles spent in HOLD at target current.
- T_TIMEOUT, 4000000, maximum cycles allowed in RAMP or RAMPDN before fault.
- I_TARGET, 2000, I_MON level that ends ramp-up.
- I_ZERO, 1, I_MON level at or below which the diode counts as off.
- CW, 24, timer width; must hold max(T_ARM, T_EMIT, T_TIMEOUT).

Ports:
- CLK  input  1  system clock
- Clr  input  1  asynchronous reset, active-high
- START  input  1  level; request an emission cycle
- STOP  input  1  level; request early termination
- INTLK_OK  input  1  safety interlock, 1 = safe
- CLR_FAULT  input  1  fault acknowledge
- I_MON  input  12  driver current readback, unsigned
- SW_ON  output  1  to driver SW_ON
- LD_ON  output  1  to driver LD_ON
- READY  output  1  1 in IDLE only
- BUSY  output  1  1 in ARM/RAMP/HOLD/RAMPDN
- FAULT  output  1  1 in FLT only
- DONE  output  1  one-cycle pulse on RAMPDN->IDLE
- STATE  output  3  current state code, for debug

Behaviour:
- Reset (Clr=1, any time, asynchronous): state=IDLE, timer=0; SW_ON=0, LD_ON=0, BUSY=0, FAULT=0, DONE=0, READY=1. Reset mid-cycle drops SW_ON/LD_ON immediately.
- All outputs are registered and decoded from the registered state; DONE is registered. Every transition takes effect on the CLK edge after its condition is sampled.
- Timer: cleared on every state change, otherwise increments by 1. Comparisons use the value before the increment.
- State codes: IDLE=0, ARM=1, RAMP=2, HOLD=3, RAMPDN=4, FLT=5. Codes 6 and 7 go to FLT.
- Output values by state (SW_ON/LD_ON): IDLE 0/0, ARM 1/0, RAMP 1/1, HOLD 1/1, RAMPDN 1/0, FLT 0/0.
- IDLE:
  - START & INTLK_OK & !STOP -> ARM.
  - START & !INTLK_OK -> stay in IDLE; no fault is raised.
- ARM:
  - !INTLK_OK -> FLT.
  - STOP -> IDLE.
  - timer==T_ARM-1 -> RAMP.
- RAMP:
  - !INTLK_OK -> FLT.
  - I_MON>=I_TARGET -> HOLD.
  - STOP -> RAMPDN.
  - timer==T_TIMEOUT-1 -> FLT.
  - Priority, highest first: INTLK, target, STOP, timeout.
- HOLD:
  - !INTLK_OK -> FLT.
  - STOP or timer==T_EMIT-1 -> RAMPDN.
- RAMPDN:
  - !INTLK_OK -> FLT.
  - I_MON<=I_ZERO -> IDLE, with DONE=1 for exactly one cycle.
  - timer==T_TIMEOUT-1 -> FLT.
  - START is ignored.
- FLT:
  - Latched fault.
  - CLR_FAULT & INTLK_OK & I_MON<=I_ZERO -> IDLE.
  - CLR_FAULT under any other condition is ignored.
- START held high after DONE re-arms on the next cycle; no edge detection.
- Simultaneous START and STOP in IDLE: no action.
- Simultaneous STOP and T_EMIT expiry in HOLD: single move to RAMPDN.
- I_MON is compared unsigned, 12-bit against 12-bit.

Decomposition:
- Shared package ld_pkg holds:
  - the state enum/localparams (IDLE..FLT, 3-bit);
  - I_TARGET default 2000 and I_ZERO default 1, also used by the driver bench.
- One natural sub-module, ld_seq_timer: CW-bit counter with synchronous clear and increment, asynchronous Clr.
- The FSM stays in ld_sequencer.

Test Plan:
- Bench setup: T_ARM=4, T_EMIT=20, T_TIMEOUT=50; a behavioural driver model ramps I_MON by 100 per cycle while LD_ON=1 and down by 100 per cycle otherwise.
- Nominal cycle: START=1 for 1 cycle with INTLK_OK=1.
  - Required: ARM for 4 cycles with SW_ON=1, LD_ON=0.
  - RAMP until I_MON>=2000, then HOLD for 20 cycles.
  - RAMPDN until I_MON<=1, then DONE pulses once and READY=1.
- Early STOP: STOP=1 in the 3rd HOLD cycle -> RAMPDN next edge, LD_ON=0, SW_ON remains 1 until I_MON reaches 0.
- Interlock drop: INTLK_OK=0 during RAMP -> FLT next edge, SW_ON=LD_ON=0, FAULT=1.
  - CLR_FAULT while I_MON=500 is ignored.
  - CLR_FAULT after I_MON=0 -> IDLE.
- Ramp timeout: driver model frozen at I_MON=1500 -> FLT on the 50th RAMP cycle; STATE=5.
- Async reset: assert Clr mid-HOLD between clock edges -> SW_ON=LD_ON=0 and STATE=0 immediately, without waiting for an edge.
  - After release, START is honored within 1 cycle.
